// File: rtl/morse_keyer_tx.sv
// Character-to-Morse transmitter: looks up a 10-bit packed code per ASCII character and keys it out.
// Optional feature: define MORSE_LOWERCASE_EN to key 'a'-'z' as their uppercase equivalents.
module morse_keyer_tx #(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic [9:0] code_out,
    output logic       code_valid,
    output logic       err
);

    localparam int unsigned CW = $clog2(4 * UNIT_CYCLES + 1);

    localparam logic [CW-1:0] ONE_U   = CW'(UNIT_CYCLES);
    localparam logic [CW-1:0] THREE_U = CW'(3 * UNIT_CYCLES);
    localparam logic [CW-1:0] FOUR_U  = CW'(4 * UNIT_CYCLES);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] MARK       = 3'd1;
    localparam logic [2:0] SYM_GAP    = 3'd2;
    localparam logic [2:0] LETTER_GAP = 3'd3;
    localparam logic [2:0] WORD_GAP   = 3'd4;

    localparam logic [9:0] CODE_SPACE = 10'b1011111111;
    localparam logic [9:0] CODE_BAD   = 10'b1111111111;

    logic [2:0]    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    code_q, code_d;
    logic          key_q, key_d;
    logic          cv_q, cv_d;
    logic          err_q, err_d;

    logic [7:0]    ch_fold;
    logic [9:0]    lut_code;
    logic [2:0]    idx_next;

    // Slot values: 00 dot, 01 dash, 11 pad; slot 0 is the MSB pair.
    function automatic logic [9:0] code_lookup(input logic [7:0] ch);
        case (ch)
            8'h20: code_lookup = CODE_SPACE;
            8'h30: code_lookup = 10'b0101010101;
            8'h31: code_lookup = 10'b0001010101;
            8'h32: code_lookup = 10'b0000010101;
            8'h33: code_lookup = 10'b0000000101;
            8'h34: code_lookup = 10'b0000000001;
            8'h35: code_lookup = 10'b0000000000;
            8'h36: code_lookup = 10'b0100000000;
            8'h37: code_lookup = 10'b0101000000;
            8'h38: code_lookup = 10'b0101010000;
            8'h39: code_lookup = 10'b0101010100;
            8'h41: code_lookup = 10'b0001111111;
            8'h42: code_lookup = 10'b0100000011;
            8'h43: code_lookup = 10'b0100010011;
            8'h44: code_lookup = 10'b0100001111;
            8'h45: code_lookup = 10'b0011111111;
            8'h46: code_lookup = 10'b0000010011;
            8'h47: code_lookup = 10'b0101001111;
            8'h48: code_lookup = 10'b0000000011;
            8'h49: code_lookup = 10'b0000111111;
            8'h4A: code_lookup = 10'b0001010111;
            8'h4B: code_lookup = 10'b0100011111;
            8'h4C: code_lookup = 10'b0001000011;
            8'h4D: code_lookup = 10'b0101111111;
            8'h4E: code_lookup = 10'b0100111111;
            8'h4F: code_lookup = 10'b0101011111;
            8'h50: code_lookup = 10'b0001010011;
            8'h51: code_lookup = 10'b0101000111;
            8'h52: code_lookup = 10'b0001001111;
            8'h53: code_lookup = 10'b0000001111;
            8'h54: code_lookup = 10'b0111111111;
            8'h55: code_lookup = 10'b0000011111;
            8'h56: code_lookup = 10'b0000000111;
            8'h57: code_lookup = 10'b0001011111;
            8'h58: code_lookup = 10'b0100000111;
            8'h59: code_lookup = 10'b0100010111;
            8'h5A: code_lookup = 10'b0101000011;
            default: code_lookup = CODE_BAD;
        endcase
    endfunction

    function automatic logic [1:0] slot_of(input logic [9:0] c, input logic [2:0] i);
        case (i)
            3'd0:    slot_of = c[9:8];
            3'd1:    slot_of = c[7:6];
            3'd2:    slot_of = c[5:4];
            3'd3:    slot_of = c[3:2];
            default: slot_of = c[1:0];
        endcase
    endfunction

    function automatic logic [CW-1:0] mark_len(input logic [1:0] s);
        mark_len = (s == 2'b01) ? THREE_U : ONE_U;
    endfunction

    always_comb begin
        ch_fold = char_in;
`ifdef MORSE_LOWERCASE_EN
        if (char_in >= 8'h61 && char_in <= 8'h7A) begin
            ch_fold = char_in - 8'h20;
        end
`endif
        lut_code = code_lookup(ch_fold);
    end

    assign idx_next = idx_q + 3'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        cv_d    = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (char_valid) begin
                    code_d = lut_code;
                    cv_d   = 1'b1;
                    idx_d  = '0;
                    if (lut_code == CODE_BAD) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else if (lut_code == CODE_SPACE) begin
                        state_d = WORD_GAP;
                        cnt_d   = FOUR_U;
                    end else begin
                        state_d = MARK;
                        cnt_d   = mark_len(slot_of(lut_code, 3'd0));
                    end
                end
            end
            MARK: begin
                if (cnt_q <= CW'(1)) begin
                    // A fifth symbol never looks ahead: slot index 4 always ends the letter.
                    if (idx_q < 3'd4 && slot_of(code_q, idx_next) != 2'b11) begin
                        state_d = SYM_GAP;
                        cnt_d   = ONE_U;
                    end else begin
                        state_d = LETTER_GAP;
                        cnt_d   = THREE_U;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SYM_GAP: begin
                if (cnt_q <= CW'(1)) begin
                    idx_d   = idx_next;
                    state_d = MARK;
                    cnt_d   = mark_len(slot_of(code_q, idx_next));
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            LETTER_GAP, WORD_GAP: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        key_d = (state_d == MARK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            key_q   <= 1'b0;
            cv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            key_q   <= key_d;
            cv_q    <= cv_d;
            err_q   <= err_d;
        end
    end

    assign char_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign key_out    = key_q;
    assign code_out   = code_q;
    assign code_valid = cv_q;
    assign err        = err_q;

endmodule

// File: tb/tb_morse_keyer_tx.sv
// Bench for morse_keyer_tx: a dot/dash-string model builds the expected per-cycle trace for each character.
module tb_morse_keyer_tx;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready, key_out, busy, code_valid, err;
    logic [9:0] code_out;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    typedef struct {
        logic       key;
        logic       bsy;
        logic       rdy;
        logic       cv;
        logic       er;
        logic [9:0] code;
    } exp_t;

    exp_t eq[$];
    exp_t cur;

    morse_keyer_tx #(.UNIT_CYCLES(U)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .key_out    (key_out),
        .busy       (busy),
        .code_out   (code_out),
        .code_valid (code_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Human-readable Morse; "?" means unsupported, " " means word space.
    function automatic string morse_of(input logic [7:0] ch);
        logic [7:0] c;
        c = ch;
`ifdef MORSE_LOWERCASE_EN
        if (c >= "a" && c <= "z") c = c - 8'h20;
`endif
        case (c)
            " ": return " ";
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
            "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
            "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
            "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
            "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
            "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
            "8": return "---.."; "9": return "----.";
            default: return "?";
        endcase
    endfunction

    function automatic logic [9:0] pack(input string m);
        logic [9:0] code;
        if (m == "?") return 10'b1111111111;
        if (m == " ") return 10'b1011111111;
        code = 10'b1111111111;
        for (int i = 0; i < m.len(); i++) begin
            code[9 - 2*i -: 2] = (m[i] == 8'h2D) ? 2'b01 : 2'b00;
        end
        return code;
    endfunction

    // Number of busy cycles a supported character occupies.
    function automatic int busy_len(input string m);
        int n;
        if (m == "?") return 0;
        if (m == " ") return 4 * U;
        n = 3 * U;
        for (int i = 0; i < m.len(); i++) begin
            n += (m[i] == 8'h2D) ? 3 * U : U;
            if (i < m.len() - 1) n += U;
        end
        return n;
    endfunction

    // Handshake one character and queue its expected trace; returns the number of queued cycles.
    task automatic start_char(input logic [7:0] c, output int n);
        string m;
        logic [9:0] code;
        logic wave[$];
        exp_t e;
        m = morse_of(c);
        code = pack(m);
        if (m != "?" && m != " ") begin
            for (int i = 0; i < m.len(); i++) begin
                repeat ((m[i] == 8'h2D) ? 3 * U : U) wave.push_back(1'b1);
                if (i < m.len() - 1) repeat (U) wave.push_back(1'b0);
            end
            repeat (3 * U) wave.push_back(1'b0);
        end else if (m == " ") begin
            repeat (4 * U) wave.push_back(1'b0);
        end
        char_in = c;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_in = 8'hxx;
        if (m == "?") begin
            e = '{key: 1'b0, bsy: 1'b0, rdy: 1'b1, cv: 1'b1, er: 1'b1, code: code};
            eq.push_back(e);
        end else begin
            foreach (wave[k]) begin
                e = '{key: wave[k], bsy: 1'b1, rdy: 1'b0, cv: (k == 0), er: 1'b0, code: code};
                eq.push_back(e);
            end
        end
        e = '{key: 1'b0, bsy: 1'b0, rdy: 1'b1, cv: 1'b0, er: 1'b0, code: code};
        eq.push_back(e);
        n = eq.size();
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        start_char(c, n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (eq.size() > 0) begin
            cur = eq.pop_front();
            check("key_out",    32'(key_out),    32'(cur.key));
            check("busy",       32'(busy),       32'(cur.bsy));
            check("char_ready", 32'(char_ready), 32'(cur.rdy));
            check("code_valid", 32'(code_valid), 32'(cur.cv));
            check("err",        32'(err),        32'(cur.er));
            check("code_out",   32'(code_out),   32'(cur.code));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        check("model_code_E", 32'(pack(morse_of("E"))), 32'h0FF);
        check("model_code_A", 32'(pack(morse_of("A"))), 32'h07F);
        check("model_code_5", 32'(pack(morse_of("5"))), 32'h000);
        check("model_code_0", 32'(pack(morse_of("0"))), 32'h155);
        check("model_len_E",  32'(busy_len(morse_of("E"))), 32'd16);
        check("model_len_A",  32'(busy_len(morse_of("A"))), 32'd32);
        check("model_len_0",  32'(busy_len(morse_of("0"))), 32'd88);

        #1;
        check("rst_key",   32'(key_out),    32'd0);
        check("rst_code",  32'(code_out),   32'd0);
        check("rst_cv",    32'(code_valid), 32'd0);
        check("rst_err",   32'(err),        32'd0);
        check("rst_ready", 32'(char_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        send("E");
        send("A");
        send("0");
        send(" ");
        send("#");
        send("e");
        send("S");
        send("5");
        send("Q");
        send("z");

        // Reset during the second dash of '0' (cycles 17-28).
        start_char("0", n);
        repeat (20) @(negedge clk);
        #1;
        eq.delete();
        check("pre_rst_key", 32'(key_out), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_key",   32'(key_out),    32'd0);
        check("mid_rst_busy",  32'(busy),       32'd0);
        check("mid_rst_code",  32'(code_out),   32'd0);
        check("mid_rst_ready", 32'(char_ready), 32'd1);
        char_in = "T";
        char_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hs_busy", 32'(busy),       32'd0);
        check("rst_hs_cv",   32'(code_valid), 32'd0);
        check("rst_hs_code", 32'(code_out),   32'd0);
        char_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        send("E");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
